dds_param_ctrl: RTL and testbench
=================================

DDS_PARAM_CTRL -- requirements
Module: dds_param_ctrl

Interface
REQ-001 SHALL have parameter TW_W, 32, tuning-word width.
REQ-002 SHALL have parameter TW_RESET, 32'd1_789_570, tuning word after reset.
REQ-003 SHALL have parameter TW_STEP, 32'd17_896, freq increment/decrement per Up/Down.
REQ-004 SHALL have parameter TW_MIN, 32'd17_896, lower saturation bound.
REQ-005 SHALL have parameter TW_MAX, 32'd1_073_741_824, upper saturation bound.
REQ-006 SHALL have parameter TIMEOUT_CYC, 24_000_000, edit inactivity timeout in cycles.
REQ-007 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-008 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port iBtnMode  input  1  one-cycle debounced pulse, next edit field.
REQ-010 SHALL have port iBtnUp  input  1  one-cycle pulse, increment field.
REQ-011 SHALL have port iBtnDown  input  1  one-cycle pulse, decrement field.
REQ-012 SHALL have port iBtnSel  input  1  one-cycle pulse, commit edits.
REQ-013 SHALL have port iCfgReady  input  1  DDS core accepts configuration.
REQ-014 SHALL have port oTuneWord  output  TW_W  committed phase increment.
REQ-015 SHALL have port oWaveSel  output  2  committed waveform: 0 sine, 1 square, 2 triangle, 3 saw.
REQ-016 SHALL have port oAmp  output  4  committed amplitude code.
REQ-017 SHALL have port oCfgValid  output  1  configuration offer, held until accepted.
REQ-018 SHALL have port oEditField  output  2  0 none, 1 wave, 2 freq, 3 amp (display).

Function
REQ-019 SHALL implement FSM states IDLE, EDIT_WAVE, EDIT_FREQ, EDIT_AMP, COMMIT.
REQ-020 SHALL, in IDLE on iBtnMode, copy committed values into shadow registers and go to EDIT_WAVE next cycle.
REQ-021 SHALL advance EDIT_WAVE->EDIT_FREQ->EDIT_AMP->EDIT_WAVE on iBtnMode.
REQ-022 SHALL resolve simultaneous pulses by priority Sel > Mode > Up/Down; Up and Down together = no change.
REQ-023 SHALL, in EDIT_WAVE, change shadow wave +/-1 modulo 4 (3+1->0, 0-1->3).
REQ-024 SHALL, in EDIT_FREQ, change shadow tuning word by TW_STEP, saturating at TW_MAX/TW_MIN, no wrap; comparison uses TW_W+1-bit arithmetic.
REQ-025 SHALL, in EDIT_AMP, change shadow amp +/-1, saturating at 15 and 0.
REQ-026 SHALL, on iBtnSel in any EDIT state, load committed outputs from shadow and enter COMMIT next cycle; oTuneWord/oWaveSel/oAmp update same edge.
REQ-027 SHALL assert oCfgValid exactly while in COMMIT; outputs stable while oCfgValid=1.
REQ-028 SHALL leave COMMIT to IDLE on the cycle oCfgValid&iCfgReady is sampled high; oCfgValid low next cycle.
REQ-029 SHALL ignore all button pulses in COMMIT and iBtnSel/Up/Down in IDLE.
REQ-030 SHALL count cycles without any button pulse in EDIT states; counter clears on any pulse or state entry.
REQ-031 SHALL, when the counter reaches TIMEOUT_CYC-1, discard shadow values and go to IDLE; committed outputs unchanged, no oCfgValid.
REQ-032 SHALL drive oEditField from current state (COMMIT and IDLE -> 0).
REQ-033 SHALL, after reset, present one COMMIT offer of reset values (FSM reset state COMMIT with oCfgValid=1).

Reset
REQ-034 SHALL on RESET=1 immediately set oTuneWord=TW_RESET, oWaveSel=0, oAmp=15, shadows equal, timer=0, state COMMIT, oCfgValid=1, oEditField=0.
REQ-035 SHALL abandon any edit or pending handshake when reset asserts mid-operation.

Structure
REQ-036 SHALL place state encoding, wave codes and field codes in shared package dds_ctrl_pkg.
REQ-037 SHALL implement the inactivity counter as sub-module idle_timer (clear, enable, expire pulse).

Verification
REQ-038 Reset release, iCfgReady=1 -> oCfgValid high 1 cycle, oTuneWord=1_789_570, oWaveSel=0, oAmp=15, then IDLE.
REQ-039 Mode, Up x5, Sel, ready=1 -> oWaveSel=1 (5 mod 4), one valid pulse, oEditField 1 then 0.
REQ-040 Mode x2, Up x70000, Sel -> oTuneWord=TW_MAX, no wrap; Down from TW_MIN stays TW_MIN.
REQ-041 Sel with iCfgReady=0 for 10 cycles -> oCfgValid held 10 cycles, outputs stable, buttons ignored; ready=1 -> IDLE.
REQ-042 Mode, Up, then no pulses TIMEOUT_CYC cycles (TIMEOUT_CYC=16 in sim) -> IDLE, outputs unchanged, no valid.
REQ-043 Sel+Mode+Up same cycle in EDIT_AMP -> COMMIT only; RESET mid-COMMIT -> reset values, oCfgValid=1.

Source files
------------

// File: rtl/dds_ctrl_pkg.sv
// Shared definitions for the DDS parameter controller.
// Holds the FSM state encoding, waveform and edit-field codes, field widths,
// and small helpers that map states to display fields and edit order.
package dds_ctrl_pkg;

  localparam int unsigned WAVE_W  = 2;
  localparam int unsigned AMP_W   = 4;
  localparam int unsigned FIELD_W = 2;
  localparam int unsigned STATE_W = 3;

  localparam logic [AMP_W-1:0] AMP_MAX   = AMP_W'(15);
  localparam logic [AMP_W-1:0] AMP_MIN   = AMP_W'(0);
  localparam logic [AMP_W-1:0] AMP_RESET = AMP_W'(15);

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_EDIT_WAVE = 3'd1,
    ST_EDIT_FREQ = 3'd2,
    ST_EDIT_AMP  = 3'd3,
    ST_COMMIT    = 3'd4
  } state_e;

  typedef enum logic [WAVE_W-1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  typedef enum logic [FIELD_W-1:0] {
    FIELD_NONE = 2'd0,
    FIELD_WAVE = 2'd1,
    FIELD_FREQ = 2'd2,
    FIELD_AMP  = 2'd3
  } field_e;

  // Display field shown for a given controller state.
  function automatic field_e field_of(state_e s);
    case (s)
      ST_EDIT_WAVE: field_of = FIELD_WAVE;
      ST_EDIT_FREQ: field_of = FIELD_FREQ;
      ST_EDIT_AMP:  field_of = FIELD_AMP;
      default:      field_of = FIELD_NONE;
    endcase
  endfunction

  // Edit field order wave -> freq -> amp -> wave.
  function automatic state_e next_edit(state_e s);
    case (s)
      ST_EDIT_WAVE: next_edit = ST_EDIT_FREQ;
      ST_EDIT_FREQ: next_edit = ST_EDIT_AMP;
      default:      next_edit = ST_EDIT_WAVE;
    endcase
  endfunction

endpackage

// File: rtl/dds_param_ctrl_if.sv
// Button / configuration bus of the DDS parameter controller.
// Inputs:  iBtnMode, iBtnUp, iBtnDown, iBtnSel (one-cycle pulses), iCfgReady.
// Outputs: oTuneWord, oWaveSel, oAmp (committed config), oCfgValid, oEditField.
// slave = controller side, master = buttons/DDS core side.
interface dds_param_ctrl_if
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned TW_W = 32
);
  logic               iBtnMode;
  logic               iBtnUp;
  logic               iBtnDown;
  logic               iBtnSel;
  logic               iCfgReady;
  logic [TW_W-1:0]    oTuneWord;
  logic [WAVE_W-1:0]  oWaveSel;
  logic [AMP_W-1:0]   oAmp;
  logic               oCfgValid;
  logic [FIELD_W-1:0] oEditField;

  modport slave (
    input  iBtnMode, iBtnUp, iBtnDown, iBtnSel, iCfgReady,
    output oTuneWord, oWaveSel, oAmp, oCfgValid, oEditField
  );

  modport master (
    output iBtnMode, iBtnUp, iBtnDown, iBtnSel, iCfgReady,
    input  oTuneWord, oWaveSel, oAmp, oCfgValid, oEditField
  );
endinterface

// File: rtl/dds_param_ctrl_idle_timer.sv
// Inactivity timer: counts enabled cycles, restarts on clear, and flags
// expiry on the cycle the count reaches COUNT_CYC-1 (then restarts).
// Ports: clk, rst (async active-high), clear_i, enable_i, expire_c.
module idle_timer #(
  parameter int unsigned COUNT_CYC = 24_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_c
);
  localparam int unsigned CNT_W = (COUNT_CYC > 1) ? $clog2(COUNT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT_CYC - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Clear dominates; expiry only on an uninterrupted enabled cycle.
  always_comb begin
    expire_c = 1'b0;
    count_d  = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      if (count_q == LAST) begin
        expire_c = 1'b1;
        count_d  = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/dds_param_ctrl.sv
// DDS parameter controller: button-driven editing of waveform, tuning word and
// amplitude in shadow registers, committed on Sel and offered to the DDS core
// with a valid/ready handshake. Edits are abandoned after an inactivity timeout.
// Ports: CLK, RESET (async active-high), bus (dds_param_ctrl_if.slave).
module dds_param_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned      TW_W        = 32,
  parameter logic [TW_W-1:0]  TW_RESET    = TW_W'(1_789_570),
  parameter logic [TW_W-1:0]  TW_STEP     = TW_W'(17_896),
  parameter logic [TW_W-1:0]  TW_MIN      = TW_W'(17_896),
  parameter logic [TW_W-1:0]  TW_MAX      = TW_W'(1_073_741_824),
  parameter int unsigned      TIMEOUT_CYC = 24_000_000
) (
  input  logic             CLK,
  input  logic             RESET,
  dds_param_ctrl_if.slave  bus
);
  localparam int unsigned TWX_W = TW_W + 1;
  localparam logic [TWX_W-1:0] STEP_X = TWX_W'(TW_STEP);
  localparam logic [TWX_W-1:0] MIN_X  = TWX_W'(TW_MIN);
  localparam logic [TWX_W-1:0] MAX_X  = TWX_W'(TW_MAX);

  state_e             state_q, state_d;
  logic [TW_W-1:0]    tw_q, tw_d, sh_tw_q, sh_tw_d;
  logic [WAVE_W-1:0]  wave_q, wave_d, sh_wave_q, sh_wave_d;
  logic [AMP_W-1:0]   amp_q, amp_d, sh_amp_q, sh_amp_d;
  logic               valid_q, valid_d;
  logic [FIELD_W-1:0] field_q, field_d;

  logic            in_edit, any_btn, step_up, step_dn, expire;
  logic [TWX_W-1:0] tw_up_x;
  logic [TW_W-1:0]  tw_up, tw_dn;

  assign in_edit = (state_q == ST_EDIT_WAVE) || (state_q == ST_EDIT_FREQ) ||
                   (state_q == ST_EDIT_AMP);
  assign any_btn = bus.iBtnMode | bus.iBtnUp | bus.iBtnDown | bus.iBtnSel;
  // Up and Down together cancel out.
  assign step_up = bus.iBtnUp & ~bus.iBtnDown;
  assign step_dn = bus.iBtnDown & ~bus.iBtnUp;

  // Saturating tuning-word step, one extra bit so the sum cannot wrap.
  assign tw_up_x = {1'b0, sh_tw_q} + STEP_X;
  assign tw_up   = (tw_up_x > MAX_X) ? TW_MAX : tw_up_x[TW_W-1:0];
  assign tw_dn   = ({1'b0, sh_tw_q} < (MIN_X + STEP_X)) ? TW_MIN : (sh_tw_q - TW_STEP);

  idle_timer #(
    .COUNT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk      (CLK),
    .rst      (RESET),
    .clear_i  (~in_edit | any_btn),
    .enable_i (in_edit),
    .expire_c (expire)
  );

  // Next state, shadow edits and commit; priority Sel > Mode > Up/Down > timeout.
  always_comb begin
    state_d   = state_q;
    tw_d      = tw_q;
    wave_d    = wave_q;
    amp_d     = amp_q;
    sh_tw_d   = sh_tw_q;
    sh_wave_d = sh_wave_q;
    sh_amp_d  = sh_amp_q;

    case (state_q)
      ST_COMMIT: begin
        if (valid_q && bus.iCfgReady) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.iBtnMode) begin
          sh_tw_d   = tw_q;
          sh_wave_d = wave_q;
          sh_amp_d  = amp_q;
          state_d   = ST_EDIT_WAVE;
        end
      end
      ST_EDIT_WAVE, ST_EDIT_FREQ, ST_EDIT_AMP: begin
        if (bus.iBtnSel) begin
          tw_d    = sh_tw_q;
          wave_d  = sh_wave_q;
          amp_d   = sh_amp_q;
          state_d = ST_COMMIT;
        end else if (bus.iBtnMode) begin
          state_d = next_edit(state_q);
        end else if (step_up || step_dn) begin
          case (state_q)
            ST_EDIT_WAVE: sh_wave_d = step_up ? (sh_wave_q + WAVE_W'(1)) : (sh_wave_q - WAVE_W'(1));
            ST_EDIT_FREQ: sh_tw_d   = step_up ? tw_up : tw_dn;
            ST_EDIT_AMP: begin
              if (step_up) sh_amp_d = (sh_amp_q == AMP_MAX) ? AMP_MAX : (sh_amp_q + AMP_W'(1));
              else         sh_amp_d = (sh_amp_q == AMP_MIN) ? AMP_MIN : (sh_amp_q - AMP_W'(1));
            end
            default: ;
          endcase
        end else if (expire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_COMMIT;
    endcase

    valid_d = (state_d == ST_COMMIT);
    field_d = field_of(state_d);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_COMMIT;
      tw_q      <= TW_RESET;
      wave_q    <= WAVE_SINE;
      amp_q     <= AMP_RESET;
      sh_tw_q   <= TW_RESET;
      sh_wave_q <= WAVE_SINE;
      sh_amp_q  <= AMP_RESET;
      valid_q   <= 1'b1;
      field_q   <= FIELD_NONE;
    end else begin
      state_q   <= state_d;
      tw_q      <= tw_d;
      wave_q    <= wave_d;
      amp_q     <= amp_d;
      sh_tw_q   <= sh_tw_d;
      sh_wave_q <= sh_wave_d;
      sh_amp_q  <= sh_amp_d;
      valid_q   <= valid_d;
      field_q   <= field_d;
    end
  end

  assign bus.oTuneWord  = tw_q;
  assign bus.oWaveSel   = wave_q;
  assign bus.oAmp       = amp_q;
  assign bus.oCfgValid  = valid_q;
  assign bus.oEditField = field_q;
endmodule

// File: tb/tb_dds_param_ctrl.sv
// Self-checking bench for dds_param_ctrl: directed scenarios plus random
// button/ready traffic, checked every cycle against a behavioural model.
module tb_dds_param_ctrl;
  localparam int unsigned TO    = 16;
  localparam longint TW_RESET_L = 1_789_570;
  localparam longint STEP_L     = 17_896;
  localparam longint TMIN_L     = 17_896;
  localparam longint TMAX_L     = 1_073_741_824;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dds_param_ctrl_if #(.TW_W(32)) bus ();

  dds_param_ctrl #(
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_print = 0;

  // Behavioural model: what the user sees, not how the controller is built.
  int     m_field;    // 0 none, 1 wave, 2 freq, 3 amp
  bit     m_offer;    // configuration offer outstanding
  longint m_tw, m_sh_tw;
  int     m_wave, m_sh_wave, m_amp, m_sh_amp;
  int     m_quiet;    // consecutive pulse-free editing cycles

  task automatic model_reset();
    m_field = 0; m_offer = 1'b1;
    m_tw = TW_RESET_L; m_wave = 0; m_amp = 15;
    m_sh_tw = m_tw; m_sh_wave = m_wave; m_sh_amp = m_amp;
    m_quiet = 0;
  endtask

  task automatic model_step(input bit md, input bit up, input bit dn, input bit sl, input bit rd);
    if (m_offer) begin
      if (rd) m_offer = 1'b0;
    end else if (m_field == 0) begin
      if (md) begin
        m_sh_tw = m_tw; m_sh_wave = m_wave; m_sh_amp = m_amp;
        m_field = 1; m_quiet = 0;
      end
    end else begin
      if (sl) begin
        m_tw = m_sh_tw; m_wave = m_sh_wave; m_amp = m_sh_amp;
        m_field = 0; m_offer = 1'b1;
      end else if (md) begin
        m_field = (m_field == 3) ? 1 : m_field + 1;
        m_quiet = 0;
      end else if (up || dn) begin
        m_quiet = 0;
        if (up != dn) begin
          case (m_field)
            1: m_sh_wave = up ? (m_sh_wave + 1) % 4 : (m_sh_wave + 3) % 4;
            2: begin
              if (up) m_sh_tw = (m_sh_tw + STEP_L > TMAX_L) ? TMAX_L : m_sh_tw + STEP_L;
              else    m_sh_tw = (m_sh_tw - STEP_L < TMIN_L) ? TMIN_L : m_sh_tw - STEP_L;
            end
            default: begin
              if (up) m_sh_amp = (m_sh_amp == 15) ? 15 : m_sh_amp + 1;
              else    m_sh_amp = (m_sh_amp == 0) ? 0 : m_sh_amp - 1;
            end
          endcase
        end
      end else if (m_quiet == TO - 1) begin
        m_field = 0; m_quiet = 0;
      end else begin
        m_quiet = m_quiet + 1;
      end
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
    end
  endtask

  task automatic compare_all();
    check("tune_word",  longint'(bus.oTuneWord),  m_tw);
    check("wave_sel",   longint'(bus.oWaveSel),   longint'(m_wave));
    check("amp",        longint'(bus.oAmp),       longint'(m_amp));
    check("cfg_valid",  longint'(bus.oCfgValid),  longint'(m_offer));
    check("edit_field", longint'(bus.oEditField), longint'(m_field));
  endtask

  task automatic cyc(input bit md, input bit up, input bit dn, input bit sl, input bit rd);
    bus.iBtnMode = md; bus.iBtnUp = up; bus.iBtnDown = dn; bus.iBtnSel = sl; bus.iCfgReady = rd;
    @(posedge clk);
    model_step(md, up, dn, sl, rd);
    #1;
    bus.iBtnMode = 1'b0; bus.iBtnUp = 1'b0; bus.iBtnDown = 1'b0; bus.iBtnSel = 1'b0;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.iBtnMode = 1'b0; bus.iBtnUp = 1'b0; bus.iBtnDown = 1'b0; bus.iBtnSel = 1'b0;
    bus.iCfgReady = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    do_reset();
    // Reset values as literals.
    check("rst_tune", longint'(bus.oTuneWord), 1_789_570);
    check("rst_wave", longint'(bus.oWaveSel), 0);
    check("rst_amp", longint'(bus.oAmp), 15);
    check("rst_valid", longint'(bus.oCfgValid), 1);
    check("rst_field", longint'(bus.oEditField), 0);

    // Reset offer accepted in one cycle.
    cyc(0, 0, 0, 0, 1);
    check("offer_done", longint'(bus.oCfgValid), 0);

    // Mode, Up x5, Sel: wave 5 mod 4 = 1.
    cyc(1, 0, 0, 0, 1);
    check("field_wave", longint'(bus.oEditField), 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    check("wave_commit", longint'(bus.oWaveSel), 1);
    check("wave_valid", longint'(bus.oCfgValid), 1);
    cyc(0, 0, 0, 0, 1);
    check("wave_field_0", longint'(bus.oEditField), 0);
    check("wave_valid_0", longint'(bus.oCfgValid), 0);

    // Frequency saturates at TW_MAX.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("field_freq", longint'(bus.oEditField), 2);
    for (int i = 0; i < 70000; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("tw_max", longint'(bus.oTuneWord), 1_073_741_824);

    // Offer held 10 cycles with buttons ignored, then accepted.
    for (int i = 0; i < 10; i++) cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
    check("held_valid", longint'(bus.oCfgValid), 1);
    check("held_tw", longint'(bus.oTuneWord), 1_073_741_824);
    cyc(0, 0, 0, 0, 1);
    check("held_released", longint'(bus.oCfgValid), 0);

    // Frequency saturates at TW_MIN going down from the reset value.
    do_reset();
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 120; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1);
    check("tw_min", longint'(bus.oTuneWord), 17_896);
    cyc(0, 0, 0, 0, 1);

    // Timeout: Mode, Up, then silence.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < int'(TO) - 1; i++) cyc(0, 0, 0, 0, 0);
    check("to_still_edit", longint'(bus.oEditField), 1);
    cyc(0, 0, 0, 0, 0);
    check("to_idle", longint'(bus.oEditField), 0);
    check("to_no_valid", longint'(bus.oCfgValid), 0);
    check("to_wave_kept", longint'(bus.oWaveSel), 0);
    check("to_tw_kept", longint'(bus.oTuneWord), 17_896);

    // Sel+Mode+Up in EDIT_AMP commits only; then reset mid-offer.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("field_amp", longint'(bus.oEditField), 3);
    cyc(1, 1, 0, 1, 0);
    check("prio_valid", longint'(bus.oCfgValid), 1);
    check("prio_field", longint'(bus.oEditField), 0);
    check("prio_amp", longint'(bus.oAmp), 15);
    cyc(0, 0, 0, 0, 0);
    do_reset();
    check("rst2_tune", longint'(bus.oTuneWord), 1_789_570);
    check("rst2_valid", longint'(bus.oCfgValid), 1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 3) == 0) begin
        cyc(0, 0, 0, 0, 1'($urandom_range(0, 1)));
      end else begin
        cyc($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
